// File: rtl/uart_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the serialiser state encoding.
package uart_io_pkg;

  localparam logic [3:0] REG_TXDATA  = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_BAUDDIV = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_CLR_OVF   = 1;
  localparam int CTRL_IRQ_EN    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = 1'b1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Optional interrupt output enabled by defining UART_TX_IRQ_EN.
module io_uart_tx
  import uart_io_pkg::*;
#(
  parameter int          IO_ADDR_BITS    = 4,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [15:0] BAUD_DIV_RESET  = 16'd434
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_ADDR_BITS-1:0] addressIO,
  input  logic [31:0]             dataInIO,
  output logic [31:0]             dataOutIO,
  input  logic                    wEnIO,
  output logic                    txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic                    irq
`endif
);

  logic [1:0]  sel;
  logic        wr_txdata, wr_bauddiv, wr_ctrl;
  logic [15:0] baud_div, div_m1;
  logic        enable, overflow;

  logic                     fifo_pop, fifo_full, fifo_empty;
  logic [7:0]               fifo_rdata;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  tx_state_e   state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shift, shift_next;
  logic        txd_bit;

  assign sel        = addressIO[3:2];
  assign wr_txdata  = wEnIO && (sel == REG_TXDATA[3:2]);
  assign wr_bauddiv = wEnIO && (sel == REG_BAUDDIV[3:2]);
  assign wr_ctrl    = wEnIO && (sel == REG_CTRL[3:2]);
  // A divisor of 0 behaves as 1; the counter always reloads with div-1.
  assign div_m1     = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (dataInIO[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= BAUD_DIV_RESET;
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_bauddiv) baud_div <= dataInIO[15:0];
      if (wr_ctrl)    enable   <= dataInIO[CTRL_ENABLE];
      if (wr_txdata && fifo_full && !fifo_pop)
        overflow <= 1'b1;
      else if (wr_ctrl && dataInIO[CTRL_CLR_OVF])
        overflow <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;
  logic unused_bits;
  assign unused_bits = ^{addressIO[1:0], dataInIO[31:16]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= dataInIO[CTRL_IRQ_EN];
      irq <= irq_en && (fifo_empty || overflow);
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{addressIO[1:0], dataInIO[31:16], dataInIO[CTRL_IRQ_EN]};
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    dataOutIO = '0;
    case (sel)
      REG_STATUS[3:2]: begin
        dataOutIO[STAT_BUSY]     = (state != ST_IDLE);
        dataOutIO[STAT_FULL]     = fifo_full;
        dataOutIO[STAT_EMPTY]    = fifo_empty;
        dataOutIO[STAT_OVERFLOW] = overflow;
        dataOutIO[STAT_COUNT_LSB +: FIFO_DEPTH_LOG2+1] = fifo_count;
      end
      REG_BAUDDIV[3:2]: dataOutIO[15:0] = baud_div;
      REG_CTRL[3:2]: begin
        dataOutIO[CTRL_ENABLE] = enable;
`ifdef UART_TX_IRQ_EN
        dataOutIO[CTRL_IRQ_EN] = irq_en;
`endif
      end
      default: dataOutIO = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    fifo_pop   = 1'b0;
    txd_bit    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          cnt_next   = div_m1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        txd_bit = 1'b0;
        if (cnt == 16'd0) begin
          cnt_next   = div_m1;
          idx_next   = 3'd0;
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_DATA: begin
        txd_bit = shift[0];
        if (cnt == 16'd0) begin
          cnt_next = div_m1;
          if (idx == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            idx_next   = idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt == 16'd0) state_next = ST_IDLE;
        else              cnt_next   = cnt - 16'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
      txd   <= txd_bit;
    end
  end

endmodule
